// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event path.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam logic [7:0]  PS2_BRK       = 8'hF0;
  localparam logic [7:0]  PS2_PAUSE     = 8'hE1;
  localparam int unsigned PS2_PAUSE_LEN = 7;
  localparam int unsigned SKIP_W        = 3;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_t;

  // Keyboard protocol responses and fillers that never form a key event.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == 8'hFA) ||
           (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is visible while non-empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pop only when occupied; a full FIFO still takes a push alongside a pop.
  always_comb begin
    rd_en    = pop_i && !empty_o;
    wr_en    = push_i && (!full_o || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !rd_en) count_d = count_q + CNT_W'(1);
    if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_kbd_queue.sv
// Collapses Set 2 scan-code bytes into key events and queues them for firmware.
module ps2_kbd_queue
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic [7:0]             ps2_code_i,
  input  logic                   ps2_strobe_i,
  input  logic                   ps2_err_i,
  input  logic                   rd_i,
  input  logic                   clr_flags_i,
  output logic [9:0]             data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   err_o
);

  kbd_state_t        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              overflow_q, overflow_d;
  logic              err_q, err_d;
  logic              push;
  kbd_event_t        push_ev;
  logic              fifo_full;
  logic              fifo_empty;
  logic [9:0]        head;

  // Prefix decoder: advances on each byte strobe, an error pulse aborts it.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    push    = 1'b0;
    push_ev = '0;
    if (ps2_err_i) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end else if (ps2_strobe_i) begin
      push_ev.code = ps2_code_i;
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_code_i == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_code_i == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (ps2_code_i == PS2_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = SKIP_W'(PS2_PAUSE_LEN);
          end else if (!is_discard(ps2_code_i)) begin
            push = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2_code_i == PS2_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (ps2_code_i != PS2_EXT) begin
            push_ev.ext = 1'b1;
            push        = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_ev.brk = 1'b1;
          push        = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_ev.brk = 1'b1;
          push_ev.ext = 1'b1;
          push        = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_PAUSE: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            push_ev.ext  = 1'b1;
            push_ev.code = PS2_PAUSE;
            push         = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky flags: clear first so a same-cycle set event wins.
  always_comb begin
    overflow_d = overflow_q;
    err_d      = err_q;
    if (clr_flags_i) begin
      overflow_d = 1'b0;
      err_d      = 1'b0;
    end
    if (push && fifo_full && !rd_i) overflow_d = 1'b1;
    if (ps2_err_i) err_d = 1'b1;
  end

  // Decoder and flag registers.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(kbd_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset_i),
    .push_i      (push),
    .push_data_i (push_ev),
    .pop_i       (rd_i),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count_o)
  );

  assign data_o     = head;
  assign valid_o    = !fifo_empty;
  assign overflow_o = overflow_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ps2_kbd_queue.sv
// Directed self-checking bench for ps2_kbd_queue.
module tb_ps2_kbd_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [7:0]    ps2_code_i;
  logic          ps2_strobe_i;
  logic          ps2_err_i;
  logic          rd_i;
  logic          clr_flags_i;
  logic [9:0]    data_o;
  logic          valid_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_kbd_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .ps2_code_i   (ps2_code_i),
    .ps2_strobe_i (ps2_strobe_i),
    .ps2_err_i    (ps2_err_i),
    .rd_i         (rd_i),
    .clr_flags_i  (clr_flags_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_code_i   = b;
    ps2_strobe_i = 1'b1;
    tick();
    ps2_strobe_i = 1'b0;
  endtask

  task automatic pop();
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    reset_i = 1'b1; ps2_code_i = '0; ps2_strobe_i = 0; ps2_err_i = 0;
    rd_i = 0; clr_flags_i = 0;
    tick(); tick();
    check("rst_valid", 32'(valid_o), 0);
    check("rst_count", 32'(count_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_data", 32'(data_o), 0);
    reset_i = 1'b0;
    tick();

    // Plain make code
    send(8'h1C);
    check("make_valid", 32'(valid_o), 1);
    check("make_data", 32'(data_o), 32'h01C);
    check("make_count", 32'(count_o), 1);
    pop();
    check("pop_valid", 32'(valid_o), 0);
    check("pop_count", 32'(count_o), 0);
    pop();
    check("pop_empty_count", 32'(count_o), 0);

    // Extended break
    send(8'hE0); send(8'hF0);
    check("extbrk_pending", 32'(count_o), 0);
    send(8'h75);
    check("extbrk_data", 32'(data_o), 32'h375);
    check("extbrk_count", 32'(count_o), 1);
    pop();
    send(8'hF0); send(8'h1C);
    check("brk_data", 32'(data_o), 32'h21C);
    pop();

    // Pause sequence
    for (int i = 0; i < 7; i++) send(pause_seq[i]);
    check("pause_pending", 32'(count_o), 0);
    send(pause_seq[7]);
    check("pause_count", 32'(count_o), 1);
    check("pause_data", 32'(data_o), 32'h1E1);
    send(8'h1C);
    check("after_pause_count", 32'(count_o), 2);
    pop();
    check("after_pause_data", 32'(data_o), 32'h01C);
    pop();

    // Protocol responses are dropped
    send(8'hAA); send(8'hFA); send(8'hE0); send(8'hE0); send(8'h11);
    check("discard_count", 32'(count_o), 1);
    check("ext_repeat_data", 32'(data_o), 32'h111);
    pop();

    // Fill past capacity
    for (int i = 0; i < DEPTH + 2; i++) send(8'(8'h10 + i));
    check("full_count", 32'(count_o), DEPTH);
    check("full_ovf", 32'(overflow_o), 1);
    clr_flags_i = 1'b1; tick(); clr_flags_i = 1'b0;
    check("clr_ovf", 32'(overflow_o), 0);
    clr_flags_i = 1'b1; send(8'h41); clr_flags_i = 1'b0;
    check("set_wins_ovf", 32'(overflow_o), 1);
    clr_flags_i = 1'b1; tick(); clr_flags_i = 1'b0;
    check("full_head", 32'(data_o), 32'h010);
    rd_i = 1'b1; send(8'h40); rd_i = 1'b0;
    check("pushpop_count", 32'(count_o), DEPTH);
    check("pushpop_ovf", 32'(overflow_o), 0);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("drain_%0d", i), 32'(data_o), 32'(8'h10 + i));
      pop();
    end
    check("drain_last", 32'(data_o), 32'h040);
    pop();
    check("drain_empty", 32'(valid_o), 0);

    // Error drops the prefix
    send(8'hE0);
    ps2_err_i = 1'b1; tick(); ps2_err_i = 1'b0;
    send(8'h1C);
    check("err_data", 32'(data_o), 32'h01C);
    check("err_flag", 32'(err_o), 1);
    clr_flags_i = 1'b1; tick(); clr_flags_i = 1'b0;
    check("err_clr", 32'(err_o), 0);
    pop();
    ps2_err_i = 1'b1; send(8'h22); ps2_err_i = 1'b0;
    check("err_strobe_count", 32'(count_o), 0);
    check("err_strobe_flag", 32'(err_o), 1);

    // Asynchronous reset mid-sequence
    send(8'h1C); send(8'h1D); send(8'h1E); send(8'hE0);
    check("pre_rst_count", 32'(count_o), 3);
    #2 reset_i = 1'b1;
    #1;
    check("async_count", 32'(count_o), 0);
    check("async_valid", 32'(valid_o), 0);
    check("async_err", 32'(err_o), 0);
    check("async_data", 32'(data_o), 0);
    tick();
    reset_i = 1'b0;
    tick();
    send(8'h74);
    check("post_rst_data", 32'(data_o), 32'h074);
    check("post_rst_count", 32'(count_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
